// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline bus: decoded ID-stage fields in, registered EX-stage fields
// and hazard stall controls out.
interface id_ex_stage_if #(
   parameter int DW   = 32,
   parameter int CNTW = 16
);
   logic            flush;
   logic            valid_id;
   logic [4:0]      rs_id;
   logic [4:0]      rt_id;
   logic [4:0]      rd_id;
   logic [DW-1:0]   rd1_id;
   logic [DW-1:0]   rd2_id;
   logic [DW-1:0]   imm_id;
   logic [1:0]      WB_id;
   logic [1:0]      M_id;
   logic [3:0]      EX_id;

   logic            valid_ex;
   logic [4:0]      rs_ex;
   logic [4:0]      rt_ex;
   logic [4:0]      rd_ex;
   logic [4:0]      wn_ex;
   logic [DW-1:0]   rd1_ex;
   logic [DW-1:0]   rd2_ex;
   logic [DW-1:0]   imm_ex;
   logic [1:0]      WB_ex;
   logic [1:0]      M_ex;
   logic [3:0]      EX_ex;
   logic            pc_write;
   logic            ifid_write;
   logic [CNTW-1:0] stall_cnt;

   // ID side: drives decoded fields, observes the EX register and stall controls
   modport master (
      output flush, valid_id, rs_id, rt_id, rd_id, rd1_id, rd2_id, imm_id,
             WB_id, M_id, EX_id,
      input  valid_ex, rs_ex, rt_ex, rd_ex, wn_ex, rd1_ex, rd2_ex, imm_ex,
             WB_ex, M_ex, EX_ex, pc_write, ifid_write, stall_cnt
   );

   // pipeline register side
   modport slave (
      input  flush, valid_id, rs_id, rt_id, rd_id, rd1_id, rd2_id, imm_id,
             WB_id, M_id, EX_id,
      output valid_ex, rs_ex, rt_ex, rd_ex, wn_ex, rd1_ex, rd2_ex, imm_ex,
             WB_ex, M_ex, EX_ex, pc_write, ifid_write, stall_cnt
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// A load in EX whose rt matches a source of the instruction in ID forces one
// bubble into EX and holds PC and IF/ID for that cycle; the held instruction
// then loads normally because the bubble clears MemRead in EX.
module id_ex_stage #(
   parameter int DW   = 32,
   parameter int CNTW = 16
) (
   input logic         clk,
   input logic         rst,
   id_ex_stage_if.slave bus
);

   logic            r_valid;
   logic [4:0]      r_rs;
   logic [4:0]      r_rt;
   logic [4:0]      r_rd;
   logic [4:0]      r_wn;
   logic [DW-1:0]   r_rd1;
   logic [DW-1:0]   r_rd2;
   logic [DW-1:0]   r_imm;
   logic [1:0]      r_wb;
   logic [1:0]      r_m;
   logic [3:0]      r_ex;
   logic [CNTW-1:0] r_stall_cnt;

   logic            w_hazard;
   logic            w_bubble;
   logic            w_ctl_en;

   // load-use detection from the EX register against the sources in ID;
   // a load into $0 never stalls since $0 reads as zero regardless
   always_comb begin
      w_hazard = r_valid && r_m[1] && (r_rt != 5'd0) && bus.valid_id &&
                 ((r_rt == bus.rs_id) || (r_rt == bus.rt_id));
      w_bubble = bus.flush || w_hazard;
      w_ctl_en = bus.valid_id && !w_bubble;
   end

   // pipeline register: data fields always load, controls are zeroed on a bubble
   // or when ID holds no real instruction
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_rs    <= '0;
         r_rt    <= '0;
         r_rd    <= '0;
         r_wn    <= '0;
         r_rd1   <= '0;
         r_rd2   <= '0;
         r_imm   <= '0;
         r_wb    <= '0;
         r_m     <= '0;
         r_ex    <= '0;
      end else begin
         r_rs    <= bus.rs_id;
         r_rt    <= bus.rt_id;
         r_rd    <= bus.rd_id;
         r_wn    <= bus.EX_id[3] ? bus.rd_id : bus.rt_id;
         r_rd1   <= bus.rd1_id;
         r_rd2   <= bus.rd2_id;
         r_imm   <= bus.imm_id;
         r_valid <= w_ctl_en;
         r_wb    <= w_ctl_en ? bus.WB_id : 2'b00;
         r_m     <= w_ctl_en ? bus.M_id  : 2'b00;
         r_ex    <= w_ctl_en ? bus.EX_id : 4'b0000;
      end
   end

   // saturating count of hazard bubbles; a flush-caused bubble is not a stall
   always_ff @(posedge clk) begin
      if (rst)
         r_stall_cnt <= '0;
      else if (w_hazard && !bus.flush && (r_stall_cnt != {CNTW{1'b1}}))
         r_stall_cnt <= r_stall_cnt + 1'b1;
   end

   // drive the bus outputs
   always_comb begin
      bus.valid_ex   = r_valid;
      bus.rs_ex      = r_rs;
      bus.rt_ex      = r_rt;
      bus.rd_ex      = r_rd;
      bus.wn_ex      = r_wn;
      bus.rd1_ex     = r_rd1;
      bus.rd2_ex     = r_rd2;
      bus.imm_ex     = r_imm;
      bus.WB_ex      = r_wb;
      bus.M_ex       = r_m;
      bus.EX_ex      = r_ex;
      bus.pc_write   = !w_hazard;
      bus.ifid_write = !w_hazard;
      bus.stall_cnt  = r_stall_cnt;
   end

endmodule
